// File: rtl/rom_fetch_ctrl.sv
// Burst fetch controller: streams `count` words from a registered-read ROM,
// starting at `base_addr`, into a small output FIFO. It throttles its own
// requests so that words already in flight always have a free FIFO slot.
module rom_fetch_ctrl #(
  parameter int AW    = 20,
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count,
  input  logic          abort,
  output logic          mem_load,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW+1:0] DepthW = (PW+2)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic          done_q, done_d;
  logic          inflight_q;
  logic [PW:0]   fifoCount_q;
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [DW-1:0] fifoMem_q [DEPTH];

  logic          issue;
  logic          flush;
  logic          push;
  logic          pop;
  logic [PW+1:0] occupancy;

  // Request and FIFO control, built only from registered state so that
  // mem_load/mem_addr have no combinational path from any input.
  always_comb begin
    occupancy = {1'b0, fifoCount_q} + {{(PW+1){1'b0}}, inflight_q};
    issue     = (state_q == FETCH) && (remaining_q != '0) && (occupancy < DepthW);
    flush     = abort && (state_q != IDLE);
    push      = inflight_q && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Next-state logic for the burst sequencer; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (issue) begin
      addr_d      = addr_q + AW'(1);
      remaining_d = remaining_q - AW'(1);
    end
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = FETCH;
            addr_d      = base_addr;
            remaining_d = count;
          end
        end
      end
      FETCH: begin
        if (issue && (remaining_q == AW'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (fifoCount_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d     = IDLE;
      remaining_d = '0;
      done_d      = 1'b0;
    end
  end

  // Sequencer registers: state, address pointer, words left and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      inflight_q  <= issue && !flush;
    end
  end

  // FIFO pointers and occupancy; an abort empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else if (flush) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifoCount_q <= fifoCount_q + (PW+1)'(1);
        2'b01:   fifoCount_q <= fifoCount_q - (PW+1)'(1);
        default: fifoCount_q <= fifoCount_q;
      endcase
    end
  end

  // FIFO storage captures the ROM word returning for last cycle's request.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= mem_data;
    end
  end

  // Output drive; out_data is zeroed while empty so it reads 0 after reset.
  always_comb begin
    mem_load  = issue;
    mem_addr  = addr_q;
    out_valid = (fifoCount_q != '0);
    out_data  = out_valid ? fifoMem_q[rdPtr_q] : '0;
    busy      = (state_q != IDLE);
    done      = done_q;
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a ROM model holding mem[a] = 3*a.
module tb_rom_fetch_ctrl;

  localparam int AW    = 20;
  localparam int DW    = 20;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] count = '0;
  logic          abort = 1'b0;
  logic          mem_load;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  int passCount = 0;
  int checkCount = 0;

  logic [AW-1:0] loadAddr[$];
  int            loadCycle[$];
  logic [DW-1:0] words[$];
  int            wordCycle[$];
  int            doneCount;
  int            doneBusy;
  int            validCount;
  int            stallChanges;
  logic          stallSeen;
  logic [DW-1:0] stallData;

  rom_fetch_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .mem_load(mem_load), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered-read ROM: word for a sampled request appears next cycle.
  always @(posedge clk) begin
    if (mem_load) mem_data <= DW'({2'b00, mem_addr} * 22'd3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    loadAddr.delete(); loadCycle.delete(); words.delete(); wordCycle.delete();
    doneCount = 0; doneBusy = 0; validCount = 0; stallChanges = 0; stallSeen = 1'b0; stallData = '0;
  endtask

  task automatic beginBurst(input logic [AW-1:0] b, input logic [AW-1:0] c);
    base_addr = b; count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic collect(input int firstCycle, input int nCycles);
    for (int k = 0; k < nCycles; k++) begin
      if (mem_load) begin loadAddr.push_back(mem_addr); loadCycle.push_back(firstCycle + k); end
      if (out_valid) validCount++;
      if (out_valid && out_ready) begin words.push_back(out_data); wordCycle.push_back(firstCycle + k); end
      if (out_valid && !out_ready) begin
        if (stallSeen && (out_data !== stallData)) stallChanges++;
        stallData = out_data; stallSeen = 1'b1;
      end
      if (done) begin doneCount++; if (busy) doneBusy++; end
      tick();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checkCount++; if (mem_load !== 1'b0) $display("[TB] FAIL reset_mem_load: got %b expected 0", mem_load); else passCount++;
    checkCount++; if (mem_addr !== 20'h0) $display("[TB] FAIL reset_mem_addr: got %h expected 00000", mem_addr); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passCount++;
    checkCount++; if (out_data !== 20'h0) $display("[TB] FAIL reset_out_data: got %h expected 00000", out_data); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
    tick();
    rst_n = 1'b1;
    tick();
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); else passCount++;
  endtask

  task automatic test_basic();
    logic [AW-1:0] expA[3] = '{20'h00010, 20'h00011, 20'h00012};
    logic [DW-1:0] expW[3] = '{20'h00030, 20'h00033, 20'h00036};
    logic [AW-1:0] gotA;
    logic [DW-1:0] gotW;
    clearLog();
    out_ready = 1'b1;
    beginBurst(20'h00010, 20'd3);
    collect(1, 20);
    checkCount++; if (loadAddr.size() != 3) $display("[TB] FAIL basic_load_count: got %0d expected 3", loadAddr.size()); else passCount++;
    for (int i = 0; i < 3; i++) begin
      gotA = (i < loadAddr.size()) ? loadAddr[i] : 'x;
      checkCount++; if (gotA !== expA[i]) $display("[TB] FAIL basic_addr%0d: got %h expected %h", i, gotA, expA[i]); else passCount++;
    end
    checkCount++;
    if (loadCycle.size() != 3 || loadCycle[0] != 1 || loadCycle[2] != 3)
      $display("[TB] FAIL basic_load_cycles: got first/last %0d/%0d expected 1/3", (loadCycle.size() > 0) ? loadCycle[0] : -1, (loadCycle.size() > 2) ? loadCycle[2] : -1);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      gotW = (i < words.size()) ? words[i] : 'x;
      checkCount++; if (gotW !== expW[i]) $display("[TB] FAIL basic_word%0d: got %h expected %h", i, gotW, expW[i]); else passCount++;
    end
    checkCount++;
    if (wordCycle.size() == 0 || wordCycle[0] != 3) $display("[TB] FAIL basic_first_valid_cycle: got %0d expected 3", (wordCycle.size() > 0) ? wordCycle[0] : -1);
    else passCount++;
    checkCount++; if (doneCount != 1) $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCount); else passCount++;
    checkCount++; if (doneBusy != 0) $display("[TB] FAIL basic_done_busy: got %0d expected 0", doneBusy); else passCount++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] gotW;
    logic [DW-1:0] expW;
    clearLog();
    out_ready = 1'b0;
    beginBurst(20'h00040, 20'd8);
    collect(1, 9);
    checkCount++; if (loadAddr.size() != 4) $display("[TB] FAIL bp_stalled_loads: got %0d expected 4", loadAddr.size()); else passCount++;
    checkCount++; if (mem_load !== 1'b0) $display("[TB] FAIL bp_load_low: got %b expected 0", mem_load); else passCount++;
    checkCount++; if (out_data !== 20'h000C0) $display("[TB] FAIL bp_head_hold: got %h expected 000c0", out_data); else passCount++;
    checkCount++; if (stallChanges != 0) $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", stallChanges); else passCount++;
    out_ready = 1'b1;
    collect(10, 30);
    checkCount++; if (loadAddr.size() != 8) $display("[TB] FAIL bp_total_loads: got %0d expected 8", loadAddr.size()); else passCount++;
    checkCount++; if (words.size() != 8) $display("[TB] FAIL bp_word_count: got %0d expected 8", words.size()); else passCount++;
    for (int i = 0; i < 8; i++) begin
      expW = DW'(32'hC0 + 32'(3 * i));
      gotW = (i < words.size()) ? words[i] : 'x;
      checkCount++; if (gotW !== expW) $display("[TB] FAIL bp_word%0d: got %h expected %h", i, gotW, expW); else passCount++;
    end
    checkCount++; if (doneCount != 1) $display("[TB] FAIL bp_done_count: got %0d expected 1", doneCount); else passCount++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] expA[3] = '{20'hFFFFE, 20'hFFFFF, 20'h00000};
    logic [DW-1:0] expW[3] = '{20'hFFFFA, 20'hFFFFD, 20'h00000};
    logic [AW-1:0] gotA;
    logic [DW-1:0] gotW;
    clearLog();
    out_ready = 1'b1;
    beginBurst(20'hFFFFE, 20'd3);
    collect(1, 20);
    for (int i = 0; i < 3; i++) begin
      gotA = (i < loadAddr.size()) ? loadAddr[i] : 'x;
      checkCount++; if (gotA !== expA[i]) $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, gotA, expA[i]); else passCount++;
      gotW = (i < words.size()) ? words[i] : 'x;
      checkCount++; if (gotW !== expW[i]) $display("[TB] FAIL wrap_word%0d: got %h expected %h", i, gotW, expW[i]); else passCount++;
    end
  endtask

  task automatic test_abort();
    logic [AW-1:0] gotA;
    logic [DW-1:0] gotW;
    clearLog();
    out_ready = 1'b0;
    beginBurst(20'h00100, 20'd6);
    collect(1, 1);
    abort = 1'b1;
    collect(2, 1);
    abort = 1'b0;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL abort_out_valid: got %b expected 0", out_valid); else passCount++;
    checkCount++; if (mem_load !== 1'b0) $display("[TB] FAIL abort_mem_load: got %b expected 0", mem_load); else passCount++;
    clearLog();
    collect(3, 6);
    checkCount++; if (doneCount != 0) $display("[TB] FAIL abort_no_done: got %0d expected 0", doneCount); else passCount++;
    checkCount++; if (validCount != 0) $display("[TB] FAIL abort_discard: got %0d valid cycles expected 0", validCount); else passCount++;
    // abort coincident with start in IDLE: the start must not be taken
    abort = 1'b1; base_addr = 20'h00180; count = 20'd2; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_beats_start: got busy %b expected 0", busy); else passCount++;
    clearLog();
    collect(1, 4);
    checkCount++; if (loadAddr.size() != 0) $display("[TB] FAIL abort_start_loads: got %0d expected 0", loadAddr.size()); else passCount++;
    // fresh burst after the abort
    clearLog();
    out_ready = 1'b1;
    beginBurst(20'h00200, 20'd2);
    collect(1, 15);
    gotA = (loadAddr.size() > 0) ? loadAddr[0] : 'x;
    checkCount++; if (gotA !== 20'h00200) $display("[TB] FAIL restart_addr0: got %h expected 00200", gotA); else passCount++;
    gotA = (loadAddr.size() > 1) ? loadAddr[1] : 'x;
    checkCount++; if (gotA !== 20'h00201) $display("[TB] FAIL restart_addr1: got %h expected 00201", gotA); else passCount++;
    gotW = (words.size() > 0) ? words[0] : 'x;
    checkCount++; if (gotW !== 20'h00600) $display("[TB] FAIL restart_word0: got %h expected 00600", gotW); else passCount++;
    gotW = (words.size() > 1) ? words[1] : 'x;
    checkCount++; if (gotW !== 20'h00603) $display("[TB] FAIL restart_word1: got %h expected 00603", gotW); else passCount++;
    checkCount++; if (words.size() != 2) $display("[TB] FAIL restart_word_count: got %0d expected 2", words.size()); else passCount++;
    checkCount++; if (doneCount != 1) $display("[TB] FAIL restart_done: got %0d expected 1", doneCount); else passCount++;
  endtask

  task automatic test_zero_count();
    clearLog();
    out_ready = 1'b1;
    beginBurst(20'h00020, 20'd0);
    checkCount++; if (done !== 1'b1) $display("[TB] FAIL zero_done: got %b expected 1", done); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (mem_load !== 1'b0) $display("[TB] FAIL zero_mem_load: got %b expected 0", mem_load); else passCount++;
    tick();
    checkCount++; if (done !== 1'b0) $display("[TB] FAIL zero_done_single: got %b expected 0", done); else passCount++;
    collect(2, 5);
    checkCount++; if (loadAddr.size() != 0) $display("[TB] FAIL zero_no_loads: got %0d expected 0", loadAddr.size()); else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] gotA;
    clearLog();
    out_ready = 1'b1;
    beginBurst(20'h00300, 20'd2);
    collect(1, 1);
    base_addr = 20'h00500; count = 20'd5; start = 1'b1;
    collect(2, 1);
    start = 1'b0;
    collect(3, 15);
    checkCount++; if (loadAddr.size() != 2) $display("[TB] FAIL busy_start_loads: got %0d expected 2", loadAddr.size()); else passCount++;
    gotA = (loadAddr.size() > 1) ? loadAddr[1] : 'x;
    checkCount++; if (gotA !== 20'h00301) $display("[TB] FAIL busy_start_addr1: got %h expected 00301", gotA); else passCount++;
    checkCount++; if (doneCount != 1) $display("[TB] FAIL busy_start_done: got %0d expected 1", doneCount); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL busy_start_idle: got %b expected 0", busy); else passCount++;
  endtask

  task automatic test_reset_mid_burst();
    clearLog();
    out_ready = 1'b0;
    beginBurst(20'h00700, 20'd6);
    collect(1, 3);
    rst_n = 1'b0;
    #1;
    checkCount++; if (mem_load !== 1'b0) $display("[TB] FAIL midrst_mem_load: got %b expected 0", mem_load); else passCount++;
    checkCount++; if (mem_addr !== 20'h0) $display("[TB] FAIL midrst_mem_addr: got %h expected 00000", mem_addr); else passCount++;
    checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); else passCount++;
    checkCount++; if (out_data !== 20'h0) $display("[TB] FAIL midrst_out_data: got %h expected 00000", out_data); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passCount++;
    tick();
    rst_n = 1'b1;
    clearLog();
    collect(0, 6);
    checkCount++; if (doneCount != 0) $display("[TB] FAIL midrst_no_done: got %0d expected 0", doneCount); else passCount++;
    checkCount++; if (validCount != 0) $display("[TB] FAIL midrst_no_data: got %0d valid cycles expected 0", validCount); else passCount++;
    checkCount++; if (loadAddr.size() != 0) $display("[TB] FAIL midrst_no_loads: got %0d expected 0", loadAddr.size()); else passCount++;
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 SHALL have parameter AW, default 20, ROM address width.
REQ-002 SHALL have parameter DW, default 20, ROM data width.
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  begin a burst; sampled only in IDLE.
REQ-007 SHALL have port base_addr  in  AW  first word address, captured on start.
REQ-008 SHALL have port count  in  AW  number of words to fetch, captured on start.
REQ-009 SHALL have port abort  in  1  cancel the current burst.
REQ-010 SHALL have port mem_load  out  1  read strobe to the ROM.
REQ-011 SHALL have port mem_addr  out  AW  ROM read address.
REQ-012 SHALL have port mem_data  in  DW  ROM registered read data, valid the cycle after a sampled mem_load.
REQ-013 SHALL have port out_valid  out  1  out_data holds a fetched word.
REQ-014 SHALL have port out_ready  in  1  consumer accepts the word.
REQ-015 SHALL have port out_data  out  DW  FIFO head word.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-017 SHALL have port done  out  1  one-cycle pulse on burst completion.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN: IDLE->FETCH on start (count>0); FETCH->DRAIN when the last request issues; DRAIN->IDLE when no read is in flight and the FIFO is empty.
REQ-019 SHALL, on start with count==0, skip FETCH/DRAIN, issue no request, and pulse done in the next cycle.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL derive mem_load and mem_addr only from internal registers, with no combinational path from any input.
REQ-022 SHALL assert mem_load in FETCH when remaining>0 and fifo_count+inflight < DEPTH; inflight is a 1-bit register equal to the previous cycle's mem_load; same-cycle pops are not credited.
REQ-023 SHALL increment mem_addr by 1 modulo 2^AW after each issued request, so 0xFFFFF wraps to 0x00000; mem_addr holds otherwise.
REQ-024 SHALL write mem_data into the FIFO at the edge where inflight==1.
REQ-025 SHALL drive out_valid = FIFO non-empty and out_data = FIFO head; pop on out_valid&&out_ready; a simultaneous push and pop leaves the count unchanged.
REQ-026 SHALL sustain one word per cycle with out_ready held high; first request in the cycle after the start edge, first out_valid in the third cycle after the start edge.
REQ-027 SHALL preserve word order and never overflow the FIFO; out_data stays stable while out_valid&&!out_ready.
REQ-028 SHALL register done: high for exactly one cycle, coincident with the return to IDLE (busy low in that same cycle).
REQ-029 SHALL, on abort sampled high while busy, enter IDLE in the next cycle with FIFO emptied, inflight cleared, the returning mem_data discarded, mem_load low, and no done pulse.
REQ-030 SHALL give abort priority over a coincident start; abort in IDLE has no effect.

Reset
REQ-031 SHALL, while rst_n is low, immediately force IDLE with mem_load=0, mem_addr=0, out_valid=0, out_data=0, busy=0, done=0, FIFO empty, inflight=0, remaining=0.
REQ-032 SHALL, on reset mid-burst, drop all in-flight and buffered data, with no done pulse after release.

Verification
REQ-033 SHALL be checked with ROM mem[a]=3*a, base=0x00010, count=3, out_ready=1 -> mem_addr 0x10,0x11,0x12 on consecutive mem_load cycles; out_data 0x30,0x33,0x36; done pulses once.
REQ-034 SHALL be checked with count=8, out_ready=0 until 10 cycles after start -> exactly 4 requests issue, mem_load then stays low; after out_ready=1 all 8 words arrive in order.
REQ-035 SHALL be checked with base=0xFFFFE, count=3 -> mem_addr 0xFFFFE,0xFFFFF,0x00000.
REQ-036 SHALL be checked with abort asserted 2 cycles into a count=6 burst -> next cycle IDLE, out_valid=0, no done; a new start then fetches cleanly from its own base.
REQ-037 SHALL be checked with count=0 start, with start while busy, and with rst_n pulsed low mid-burst -> done only next cycle, start ignored, and all outputs at reset values respectively.
